sar_result_sequencer: RTL and testbench
=======================================

SAR_RESULT_SEQUENCER -- requirements
Module: sar_result_sequencer

Interface
REQ-001 SHALL provide parameter NBITS, default 5, SAR result width.
REQ-002 SHALL provide parameter NAVG_LOG2, default 2, log2 of conversions averaged per output word (4 by default).
REQ-003 SHALL provide parameter TMO, default 64, maximum CLK cycles GO may stay high without VALID.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RSTN  input  1  asynchronous, active-low reset.
REQ-006 EN  input  1  1 = run back-to-back conversions; 0 = stop.
REQ-007 GO  output  1  conversion request to the SAR logic.
REQ-008 VALID  input  1  SAR conversion finished; RESULTP is valid while high.
REQ-009 RESULTP  input  NBITS  SAR conversion result, unsigned.
REQ-010 OUT_DATA  output  NBITS  averaged result.
REQ-011 OUT_VALID  output  1  OUT_DATA holds an unconsumed word.
REQ-012 OUT_READY  input  1  downstream accepts OUT_DATA.
REQ-013 OVERRUN  output  1  sticky: an average was discarded because the output register was full.
REQ-014 TIMEOUT  output  1  sticky: VALID did not arrive within TMO cycles.

Function
REQ-015 SHALL implement FSM states IDLE, CONV, GAP.
REQ-016 IDLE: GO=0; EN=1 -> CONV next cycle.
REQ-017 CONV: GO=1; watchdog counter increments each cycle, cleared on CONV entry.
REQ-018 CONV with VALID=1: add RESULTP to accumulator (width NBITS+NAVG_LOG2, no overflow possible), increment conversion count, go to GAP.
REQ-019 GAP: GO=0 for exactly one cycle so the SAR logic restarts; then CONV if EN=1, else IDLE.
REQ-020 GO SHALL be 0 in at least one cycle between any two conversions; VALID outside CONV SHALL be ignored.
REQ-021 When the conversion count reaches 2^NAVG_LOG2, the average (accumulator >> NAVG_LOG2, truncated) SHALL be produced on the GAP cycle, accumulator and count cleared.
REQ-022 Produced average with OUT_VALID=0, or OUT_VALID=1 and OUT_READY=1 same cycle: load OUT_DATA, OUT_VALID=1.
REQ-023 Produced average with OUT_VALID=1 and OUT_READY=0: discard new average, keep OUT_DATA, set OVERRUN.
REQ-024 OUT_VALID=1 and OUT_READY=1 with no new average: OUT_VALID=0 next cycle; OUT_DATA unchanged.
REQ-025 OUT_DATA SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 Watchdog reaching TMO in CONV without VALID: set TIMEOUT, discard accumulator and count, go to IDLE (GO=0) next cycle.
REQ-027 EN=0 in CONV: abort to IDLE next cycle, GO=0, accumulator and count cleared; OUT_DATA/OUT_VALID retained.
REQ-028 OVERRUN and TIMEOUT SHALL clear only on reset or on an EN 0->1 transition seen in IDLE.
REQ-029 Latency: first GO rise one cycle after EN sampled 1; OUT_VALID rises one cycle after the final accepted VALID.

Reset
REQ-030 RSTN=0 SHALL immediately force IDLE, GO=0, OUT_VALID=0, OUT_DATA=0, OVERRUN=0, TIMEOUT=0, accumulator=0, count=0, watchdog=0.
REQ-031 Reset deassertion mid-conversion SHALL restart from IDLE; no partial average is emitted.

Verification
REQ-032 EN=1, SAR model returns 10,11,12,13, OUT_READY=1 -> OUT_DATA=11, OUT_VALID one cycle, OVERRUN=0.
REQ-033 SAR model returns 31 four times -> OUT_DATA=31 (no accumulator overflow); returns 0 four times -> OUT_DATA=0.
REQ-034 OUT_READY=0 across two averages (first 5, second 20) -> OUT_DATA stays 5, OVERRUN=1; OUT_READY=1 -> OUT_VALID falls.
REQ-035 SAR model never asserts VALID -> GO high 64 cycles, TIMEOUT=1, GO=0, FSM in IDLE; EN toggled 0->1 clears TIMEOUT.
REQ-036 EN dropped after two conversions, re-raised, then 4 conversions of 8 -> OUT_DATA=8 (partial sum discarded).
REQ-037 RSTN pulsed low mid-CONV with OUT_VALID=1 -> all outputs 0 asynchronously, GO rises again one cycle after release with EN=1.

Source files
------------

// File: rtl/sar_result_sequencer.sv
// sar_result_sequencer
// Drives back-to-back SAR conversions, averages 2^NAVG_LOG2 results per
// output word and hands the word to a valid/ready consumer.
//
// Ports
//   clk        : single clock, rising edge
//   rstn       : asynchronous active-low reset
//   en         : 1 = keep converting, 0 = stop / abort
//   go         : conversion request to the SAR logic (registered)
//   valid      : SAR conversion finished, resultp valid while high
//   resultp    : SAR result, unsigned
//   out_data   : averaged result
//   out_valid  : out_data holds an unconsumed word
//   out_ready  : downstream accepts out_data
//   overrun    : sticky, an average was dropped because out_data was full
//   timeout    : sticky, valid did not arrive within TMO cycles of go
//
// state | meaning
// IDLE  | go low, waiting for en
// CONV  | go high, waiting for valid, watchdog running
// GAP   | go low for one cycle so the SAR logic restarts

module sar_result_sequencer #(
    parameter int NBITS     = 5,
    parameter int NAVG_LOG2 = 2,
    parameter int TMO       = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic             go,
    input  logic             valid,
    input  logic [NBITS-1:0] resultp,
    output logic [NBITS-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             timeout
);

    localparam int AW = NBITS + NAVG_LOG2;
    localparam int CW = NAVG_LOG2 + 1;
    localparam int WW = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'((1 << NAVG_LOG2) - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wdog;
    logic            en_q;

    logic            accept;
    logic            produce;
    logic [AW-1:0]   sum;
    logic [NBITS-1:0] avg;

    // The final sum is averaged on the accepting edge, so the word is
    // visible during the GAP cycle right after the last valid.
    always_comb begin
        accept  = (state == CONV) && en && valid;
        sum     = acc + {{NAVG_LOG2{1'b0}}, resultp};
        avg     = sum[AW-1:NAVG_LOG2];
        produce = accept && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            go        <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            wdog      <= '0;
            en_q      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            en_q <= en;

            case (state)
                IDLE: begin
                    if (en && !en_q) begin
                        overrun <= 1'b0;
                        timeout <= 1'b0;
                    end
                    if (en) begin
                        state <= CONV;
                        go    <= 1'b1;
                        wdog  <= '0;
                    end
                end

                CONV: begin
                    if (!en) begin
                        state <= IDLE;
                        go    <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (valid) begin
                        state <= GAP;
                        go    <= 1'b0;
                        if (produce) begin
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 1'b1;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        state   <= IDLE;
                        go      <= 1'b0;
                        timeout <= 1'b1;
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                GAP: begin
                    if (en) begin
                        state <= CONV;
                        go    <= 1'b1;
                        wdog  <= '0;
                    end else begin
                        // Stopping between conversions also drops the partial sum.
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    go    <= 1'b0;
                end
            endcase

            // Output register: a new average may replace a word being
            // consumed this cycle, otherwise it is dropped and flagged.
            if (produce) begin
                if (!out_valid || out_ready) begin
                    out_data  <= avg;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sar_result_sequencer.sv
// Directed bench for sar_result_sequencer with a scoreboard of expected
// output words, popped whenever the consumer accepts a word.

module tb_sar_result_sequencer;

    localparam int NBITS = 5;

    logic             clk;
    logic             rstn;
    logic             en;
    logic             go;
    logic             valid;
    logic [NBITS-1:0] resultp;
    logic [NBITS-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             timeout;

    int n_checks = 0;
    int n_fails  = 0;
    logic [NBITS-1:0] exp_q[$];

    sar_result_sequencer #(.NBITS(5), .NAVG_LOG2(2), .TMO(64)) dut (
        .clk(clk), .rstn(rstn), .en(en), .go(go), .valid(valid),
        .resultp(resultp), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One SAR conversion: wait for go, then answer after lat cycles.
    task automatic convert(input logic [NBITS-1:0] v, input int lat);
        int n;
        n = 0;
        while (!go && n < 200) begin
            step();
            n++;
        end
        if (!go) check("go_wait_expired", 32'(go), 32'd1);
        for (int i = 0; i < lat; i++) step();
        valid   = 1'b1;
        resultp = v;
        step();
        valid   = 1'b0;
        resultp = '0;
    endtask

    // Scoreboard: a handshake seen between edges means a word is consumed.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(out_data), 32'hffff_ffff);
            end else begin
                check("out_word", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int cnt;
        rstn      = 1'b0;
        en        = 1'b0;
        valid     = 1'b0;
        resultp   = '0;
        out_ready = 1'b1;
        #12;
        check("rst_go", 32'(go), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        step();
        rstn = 1'b1;
        step();

        // 10,11,12,13 -> 11
        en = 1'b1;
        step();
        check("first_go_latency", 32'(go), 32'd1);
        convert(5'd10, 2);
        convert(5'd11, 0);
        convert(5'd12, 3);
        exp_q.push_back(5'd11);
        convert(5'd13, 1);
        check("avg1_out_valid_rise", 32'(out_valid), 32'd1);
        step();
        check("avg1_out_valid_one_cycle", 32'(out_valid), 32'd0);
        en = 1'b0;
        step(); step();
        check("avg1_overrun", 32'(overrun), 32'd0);

        // full-scale and zero
        en = 1'b1;
        for (int i = 0; i < 3; i++) convert(5'd31, i);
        exp_q.push_back(5'd31);
        convert(5'd31, 1);
        for (int i = 0; i < 3; i++) convert(5'd0, 1);
        exp_q.push_back(5'd0);
        convert(5'd0, 2);
        en = 1'b0;
        step(); step();

        // overrun: 5 is held, 20 is dropped
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) convert(5'd5, 1);
        exp_q.push_back(5'd5);
        for (int i = 0; i < 4; i++) convert(5'd20, 1);
        en = 1'b0;
        step(); step();
        check("ovr_out_data_held", 32'(out_data), 32'd5);
        check("ovr_out_valid", 32'(out_valid), 32'd1);
        check("ovr_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        step();
        check("ovr_out_valid_fall", 32'(out_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // timeout: SAR never answers
        en = 1'b1;
        step();
        check("en_rise_clears_overrun", 32'(overrun), 32'd0);
        cnt = 0;
        while (go && cnt < 200) begin
            cnt++;
            step();
        end
        check("tmo_go_cycles", 32'(cnt), 32'd64);
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_go_low", 32'(go), 32'd0);
        en = 1'b0;
        step(); step(); step();
        check("tmo_idle_go", 32'(go), 32'd0);
        check("tmo_sticky", 32'(timeout), 32'd1);
        en = 1'b1;
        step();
        check("tmo_cleared", 32'(timeout), 32'd0);
        check("tmo_restart_go", 32'(go), 32'd1);

        // abort after two conversions discards the partial sum
        convert(5'd3, 1);
        convert(5'd3, 1);
        step();
        check("abort_in_conv", 32'(go), 32'd1);
        en = 1'b0;
        step();
        check("abort_go_low", 32'(go), 32'd0);
        step();
        en = 1'b1;
        for (int i = 0; i < 3; i++) convert(5'd8, 1);
        exp_q.push_back(5'd8);
        convert(5'd8, 1);
        en = 1'b0;
        step(); step();

        // asynchronous reset mid-conversion with a held word
        out_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) convert(5'd7, 1);
        step();
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_go", 32'(go), 32'd1);
        rstn = 1'b0;
        #1;
        check("arst_go", 32'(go), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        out_ready = 1'b1;
        step();
        rstn = 1'b1;
        check("release_go_low", 32'(go), 32'd0);
        step();
        check("release_go_rise", 32'(go), 32'd1);
        en = 1'b0;
        step(); step();
        check("release_no_word", 32'(out_valid), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
